fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and a direct-mapped
// branch target buffer with 2-bit saturating counters trained by execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  input  logic        Update_En,
  input  logic [31:0] Update_PC,
  input  logic        Update_Taken,
  input  logic [31:0] Update_Target,
  output logic [31:0] Instr_Addr_F,
  input  logic [31:0] Instr_RD_F,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Predict_Taken_F
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic [31:0]                   pc_q, pc_d;
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      target_q, target_d;

  logic [BTB_IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic                 f_hit, u_hit, upd_en, predict_taken;
  logic [31:0]          pc_plus_4;
  logic                 upd_pc_lsb_unused;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // Branch PCs are word aligned; the low bits take no part in indexing or tags.
  assign upd_pc_lsb_unused = ^Update_PC[1:0];

  always_comb begin
    f_idx         = pc_q[BTB_IDX_W+1:2];
    f_tag         = pc_q[31:BTB_IDX_W+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    predict_taken = f_hit && ctr_q[f_idx][1];
    pc_plus_4     = pc_q + 32'd4;
  end

  always_comb begin
    pc_d = pc_plus_4;
    if (Redirect_En) begin
      pc_d = Redirect_PC;
    end else if (Stall_En) begin
      pc_d = pc_q;
    end else if (predict_taken) begin
      pc_d = target_q[f_idx];
    end
  end

  // Training reads the pre-update table, so a same-cycle lookup sees old contents.
  always_comb begin
    u_idx    = Update_PC[BTB_IDX_W+1:2];
    u_tag    = Update_PC[31:BTB_IDX_W+2];
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    upd_en   = Update_En && !RST;
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_en) begin
      if (u_hit) begin
        if (Update_Taken) begin
          ctr_d[u_idx]    = ctr_inc(ctr_q[u_idx]);
          target_d[u_idx] = Update_Target;
        end else begin
          ctr_d[u_idx] = ctr_dec(ctr_q[u_idx]);
        end
      end else if (Update_Taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = Update_Target;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target storage is meaningless while the valid bit is clear.
  always_ff @(posedge CLK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign PC_F            = pc_q;
  assign Instr_Addr_F    = pc_q;
  assign Instr_F         = Instr_RD_F;
  assign PC_Plus_4_F     = pc_plus_4;
  assign Predict_Taken_F = predict_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan steps followed by randomized traffic,
// checked every cycle against a table-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          IDXW   = 4;
  localparam int          N      = 1 << IDXW;
  localparam int          SH     = IDXW + 2;

  logic        clk;
  logic        rst;
  logic        stall_en;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] instr_addr_f;
  logic [31:0] instr_rd_f;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;
  logic        predict_taken_f;

  int checks;
  int passed;
  int fails;

  // Reference model: each entry remembers the full PC of the branch it holds.
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_bpc [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  fetch_unit #(.RESET_PC(RST_PC), .BTB_IDX_W(IDXW)) dut (
    .CLK            (clk),
    .RST            (rst),
    .Stall_En       (stall_en),
    .Redirect_En    (redirect_en),
    .Redirect_PC    (redirect_pc),
    .Update_En      (update_en),
    .Update_PC      (update_pc),
    .Update_Taken   (update_taken),
    .Update_Target  (update_target),
    .Instr_Addr_F   (instr_addr_f),
    .Instr_RD_F     (instr_rd_f),
    .Instr_F        (instr_f),
    .PC_F           (pc_f),
    .PC_Plus_4_F    (pc_plus_4_f),
    .Predict_Taken_F(predict_taken_f)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  assign instr_rd_f = mem_word(instr_addr_f);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = slot(pc);
    return m_v[i] && ((m_bpc[i] >> SH) == (pc >> SH));
  endfunction

  function automatic bit m_predict(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = RST_PC;
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 1'b0;
      m_ctr[i] = 1;
    end
    m_valid = 1'b1;
  endtask

  task automatic m_clock();
    logic [31:0] nxt;
    int          u;
    if (rst) begin
      m_reset();
      return;
    end
    if (redirect_en)             nxt = redirect_pc;
    else if (stall_en)           nxt = m_pc;
    else if (m_predict(m_pc))    nxt = m_tgt[slot(m_pc)];
    else                         nxt = m_pc + 32'd4;
    if (update_en) begin
      u = slot(update_pc);
      if (m_hit(update_pc)) begin
        if (update_taken) begin
          if (m_ctr[u] < 3) m_ctr[u] = m_ctr[u] + 1;
          m_tgt[u] = update_target;
        end else if (m_ctr[u] > 0) begin
          m_ctr[u] = m_ctr[u] - 1;
        end
      end else if (update_taken) begin
        m_v[u]   = 1'b1;
        m_bpc[u] = update_pc;
        m_tgt[u] = update_target;
        m_ctr[u] = 2;
      end
    end
    m_pc = nxt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic do_cycle(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                          input logic up, input logic [31:0] upc, input logic tk,
                          input logic [31:0] tgt);
    rst = r; stall_en = st; redirect_en = rd; redirect_pc = rpc;
    update_en = up; update_pc = upc; update_taken = tk; update_target = tgt;
    #4;
    if (m_valid) begin
      check("pc_f",      pc_f,            m_pc);
      check("instr_adr", instr_addr_f,    m_pc);
      check("pc_plus_4", pc_plus_4_f,     m_pc + 32'd4);
      check("instr_f",   instr_f,         mem_word(m_pc));
      check("predict",   {31'b0, predict_taken_f}, {31'b0, m_predict(m_pc)});
    end
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_now(input string tag, input logic [31:0] pc, input logic pred);
    check({tag, "_pc"},   pc_f, pc);
    check({tag, "_pred"}, {31'b0, predict_taken_f}, {31'b0, pred});
  endtask

  initial begin
    logic [31:0] a, b, c;
    checks = 0; passed = 0; fails = 0; m_valid = 1'b0; m_pc = '0;
    rst = 1'b0; stall_en = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    @(posedge clk);
    #1;

    // Reset and sequential fetch
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("rst", 32'h0, 1'b0);
    check("rst_pc4", pc_plus_4_f, 32'h4);
    idle(); expect_now("seq1", 32'h4, 1'b0);
    idle(); expect_now("seq2", 32'h8, 1'b0);
    idle(); expect_now("seq3", 32'hC, 1'b0);
    idle(); expect_now("seq4", 32'h10, 1'b0);

    // Stall holds; redirect beats stall
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      expect_now("stall", 32'h10, 1'b0);
    end
    do_cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("redir_stall", 32'h200, 1'b0);

    // Allocation then predicted-taken fetch
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("alloc", 32'h40, 1'b1);
    idle(); expect_now("alloc_tgt", 32'h100, 1'b0);

    // Saturate up, then back down to weakly not-taken
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("train_nt", 32'h40, 1'b0);
    idle(); expect_now("train_seq", 32'h44, 1'b0);

    // Aliasing entry with a different tag
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("alias", 32'h80, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("alias_keep", 32'h40, 1'b1);

    // Address wrap
    do_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("wrap", 32'hFFFF_FFFC, 1'b0);
    check("wrap_pc4", pc_plus_4_f, 32'h0);
    idle(); expect_now("wrap_next", 32'h0, 1'b0);

    // Reset discards a same-cycle update and redirect, and empties the BTB
    do_cycle(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h40, 1'b1, 32'h100);
    expect_now("rst_mid", RST_PC, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_now("rst_empty", 32'h40, 1'b0);

    // Randomized traffic concentrated on a small address window
    for (int n = 0; n < 600; n++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0400;
      b = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) b = b | 32'h0000_0400;
      c = 32'($urandom_range(0, 63)) << 2;
      do_cycle($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 12, c,
               $urandom_range(0, 99) < 50, a,
               $urandom_range(0, 99) < 65, b);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
